// File: rtl/ascon_rng_pkg.sv
// Shared types and default constants for the RNG nonce reader.
package ascon_rng_pkg;

   typedef enum logic [1:0] {WARMUP, FILL, HOLD, ALARM} nonce_state_e;

   localparam int unsigned NONCE_WIDTH        = 128;
   localparam int unsigned DEF_SAMPLE_DIV     = 4;
   localparam int unsigned DEF_WARMUP_SAMPLES = 8;
   localparam int unsigned DEF_RCT_CUTOFF     = 2;
   localparam int unsigned DEF_APT_WINDOW     = 16;
   localparam int unsigned DEF_APT_CUTOFF     = 14;

endpackage

// File: rtl/rng_health_test.sv
// Continuous RCT and APT health tests on decimated RNG samples.
module rng_health_test
   import ascon_rng_pkg::*;
#(
   parameter int unsigned WIDTH      = NONCE_WIDTH,
   parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF,
   parameter int unsigned APT_WINDOW = DEF_APT_WINDOW,
   parameter int unsigned APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sample,
   input  logic             tick,
   input  logic             clear,
   output logic             fail,
   output logic             pass
);

   localparam int unsigned REP_W = $clog2(RCT_CUTOFF + 1);
   localparam int unsigned CNT_W = $clog2(APT_WINDOW + 1);
   localparam int unsigned IDX_W = $clog2(APT_WINDOW);

   logic [WIDTH-1:0] prev_q, prev_d;
   logic             first_q, first_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [CNT_W-1:0] apt_cnt_q, apt_cnt_d;
   logic [IDX_W-1:0] apt_idx_q, apt_idx_d;
   logic             ref_q, ref_d;
   logic             fail_q, fail_now;

   always_comb begin
      prev_d    = prev_q;
      first_d   = first_q;
      rep_d     = rep_q;
      apt_cnt_d = apt_cnt_q;
      apt_idx_d = apt_idx_q;
      ref_d     = ref_q;
      if (tick) begin
         prev_d  = sample;
         first_d = 1'b0;
         if (first_q || (sample != prev_q)) begin
            rep_d = REP_W'(1);
         end else if (rep_q < REP_W'(RCT_CUTOFF)) begin
            rep_d = rep_q + REP_W'(1);
         end
         if (apt_idx_q == '0) begin
            ref_d     = sample[0];
            apt_cnt_d = CNT_W'(1);
         end else if ((sample[0] == ref_q) && (apt_cnt_q < CNT_W'(APT_CUTOFF))) begin
            apt_cnt_d = apt_cnt_q + CNT_W'(1);
         end
         apt_idx_d = (apt_idx_q == IDX_W'(APT_WINDOW - 1)) ? '0 : apt_idx_q + IDX_W'(1);
      end
      fail_now = tick && ((rep_d >= REP_W'(RCT_CUTOFF)) || (apt_cnt_d >= CNT_W'(APT_CUTOFF)));
      pass     = tick && !fail_now;
      if (clear) begin
         first_d   = 1'b1;
         rep_d     = '0;
         apt_cnt_d = '0;
         apt_idx_d = '0;
         ref_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q    <= '0;
         first_q   <= 1'b1;
         rep_q     <= '0;
         apt_cnt_q <= '0;
         apt_idx_q <= '0;
         ref_q     <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         first_q   <= first_d;
         rep_q     <= rep_d;
         apt_cnt_q <= apt_cnt_d;
         apt_idx_q <= apt_idx_d;
         ref_q     <= ref_d;
         fail_q    <= fail_now;
      end
   end

   assign fail = fail_q;

endmodule

// File: rtl/rng_nonce_reader.sv
// Samples the free-running RNG, health-tests every sample and hands out fresh nonces.
module rng_nonce_reader
   import ascon_rng_pkg::*;
#(
   parameter int unsigned WIDTH          = NONCE_WIDTH,
   parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
   parameter int unsigned WARMUP_SAMPLES = DEF_WARMUP_SAMPLES,
   parameter int unsigned RCT_CUTOFF     = DEF_RCT_CUTOFF,
   parameter int unsigned APT_WINDOW     = DEF_APT_WINDOW,
   parameter int unsigned APT_CUTOFF     = DEF_APT_CUTOFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rng_data,
   input  logic             nonce_ready,
   input  logic             clear_alarm,
   output logic [WIDTH-1:0] nonce_out,
   output logic             nonce_valid,
   output logic             alarm,
   output logic [15:0]      issued_count
);

   localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
   localparam int unsigned WARM_W = $clog2(WARMUP_SAMPLES + 1);

   nonce_state_e      state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [WIDTH-1:0]  nonce_q, nonce_d, last_q, last_d;
   logic              valid_q, valid_d, alarm_q, alarm_d;
   logic [15:0]       issued_q, issued_d;
   logic              sample_tick, test_tick, test_clear, fail, pass;

   assign sample_tick = (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign test_tick   = sample_tick && (state_q != ALARM);
   assign test_clear  = (state_q == ALARM) && clear_alarm;

   rng_health_test #(
      .WIDTH      (WIDTH),
      .RCT_CUTOFF (RCT_CUTOFF),
      .APT_WINDOW (APT_WINDOW),
      .APT_CUTOFF (APT_CUTOFF)
   ) u_health (
      .clk    (clk),
      .reset  (reset),
      .sample (rng_data),
      .tick   (test_tick),
      .clear  (test_clear),
      .fail   (fail),
      .pass   (pass)
   );

   always_comb begin
      state_d  = state_q;
      div_d    = sample_tick ? '0 : div_q + DIV_W'(1);
      warm_d   = warm_q;
      nonce_d  = nonce_q;
      last_d   = last_q;
      valid_d  = valid_q;
      alarm_d  = alarm_q;
      issued_d = issued_q;
      unique case (state_q)
         WARMUP: begin
            if (pass) begin
               if (warm_q == WARM_W'(WARMUP_SAMPLES - 1)) begin
                  warm_d  = '0;
                  state_d = FILL;
               end else begin
                  warm_d = warm_q + WARM_W'(1);
               end
            end
         end
         FILL: begin
            // A repeat of the last delivered nonce is dropped, never re-issued.
            if (pass && (rng_data != last_q)) begin
               nonce_d = rng_data;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (valid_q && nonce_ready) begin
               valid_d = 1'b0;
               last_d  = nonce_q;
               state_d = FILL;
               if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
            end
         end
         ALARM: begin
            if (clear_alarm) begin
               alarm_d = 1'b0;
               warm_d  = '0;
               state_d = WARMUP;
            end
         end
         default: state_d = WARMUP;
      endcase
      // A health failure overrides the state move but not a completing handshake.
      if (fail) begin
         state_d = ALARM;
         alarm_d = 1'b1;
         valid_d = 1'b0;
         nonce_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= WARMUP;
         div_q    <= '0;
         warm_q   <= '0;
         nonce_q  <= '0;
         last_q   <= '0;
         valid_q  <= 1'b0;
         alarm_q  <= 1'b0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         warm_q   <= warm_d;
         nonce_q  <= nonce_d;
         last_q   <= last_d;
         valid_q  <= valid_d;
         alarm_q  <= alarm_d;
         issued_q <= issued_d;
      end
   end

   assign nonce_out    = nonce_q;
   assign nonce_valid  = valid_q;
   assign alarm        = alarm_q;
   assign issued_count = issued_q;

endmodule

// File: tb/tb_rng_nonce_reader.sv
// Scoreboard bench: expected nonces are queued by stimulus and checked by a monitor.
module tb_rng_nonce_reader;

   logic         clk;
   logic         reset;
   logic [127:0] rng_data;
   logic         nonce_ready;
   logic         clear_alarm;
   logic [127:0] nonce_out;
   logic         nonce_valid;
   logic         alarm;
   logic [15:0]  issued_count;

   rng_nonce_reader dut (
      .clk          (clk),
      .reset        (reset),
      .rng_data     (rng_data),
      .nonce_ready  (nonce_ready),
      .clear_alarm  (clear_alarm),
      .nonce_out    (nonce_out),
      .nonce_valid  (nonce_valid),
      .alarm        (alarm),
      .issued_count (issued_count)
   );

   typedef struct {
      logic [127:0] nonce;
      int           edge_n;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   ecnt;
   int   mode = 0;
   logic mon_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Rising edges since reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   // mode 0: distinct, bit0 alternates per tick; 1: constant; 2: distinct, bit0 always 1
   function automatic logic [127:0] gen(input int m, input int c);
      logic [31:0]  cc;
      logic [127:0] v;
      cc = c;
      if (m == 1) begin
         v = {4{32'hA5A5A5A5}};
      end else begin
         v = {cc ^ 32'h9E3779B9, cc * 32'h01000193, ~cc, cc << 3};
         v[0] = (m == 2) ? 1'b1 : cc[2];
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (edge %0d)", name, got, exp, ecnt);
      end
   endtask

   task automatic push(input int e);
      exp_t x;
      x.nonce  = gen(mode, e);
      x.edge_n = e;
      sb.push_back(x);
   endtask

   task automatic adv();
      rng_data = gen(mode, ecnt + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic adv_to(input int n);
      while (ecnt < n) adv();
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      nonce_ready = 1'b0;
      clear_alarm = 1'b0;
      #1;
      chk("rst_nonce_out", nonce_out, '0);
      chk("rst_valid", {127'd0, nonce_valid}, '0);
      chk("rst_alarm", {127'd0, alarm}, '0);
      chk("rst_issued", {112'd0, issued_count}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic scenario_fresh();
      do_reset();
      mode        = 0;
      nonce_ready = 1'b1;
      push(36);
      adv_to(35);
      chk("s1_valid_before", {127'd0, nonce_valid}, '0);
      adv_to(36);
      chk("s1_valid_at36", {127'd0, nonce_valid}, 128'd1);
      chk("s1_nonce_at36", nonce_out, gen(0, 36));
      adv_to(37);
      chk("s1_issued_at37", {112'd0, issued_count}, 128'd1);
      chk("s1_valid_at37", {127'd0, nonce_valid}, '0);
   endtask

   // Monitor: every new nonce presentation must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset && nonce_valid && !mon_prev) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_nonce: got=%h at edge %0d, none expected", nonce_out, ecnt);
         end else begin
            mon_e = sb.pop_front();
            if (nonce_out !== mon_e.nonce || ecnt != mon_e.edge_n) begin
               bad++;
               $display("FAIL sb_nonce: got=%h@%0d expected=%h@%0d",
                        nonce_out, ecnt, mon_e.nonce, mon_e.edge_n);
            end
         end
      end
      mon_prev = nonce_valid;
   end

   initial begin
      rng_data    = '0;
      nonce_ready = 1'b0;
      clear_alarm = 1'b0;
      reset       = 1'b0;

      // Normal first nonce.
      scenario_fresh();

      // Constant data: RCT fails on the 2nd tick.
      do_reset();
      mode        = 1;
      nonce_ready = 1'b1;
      adv_to(8);
      chk("s2_alarm_at8", {127'd0, alarm}, '0);
      adv_to(9);
      chk("s2_alarm_at9", {127'd0, alarm}, 128'd1);
      for (int i = 0; i < 12; i++) begin
         adv_to(ecnt + 4);
         chk("s2_alarm_sticky", {127'd0, alarm}, 128'd1);
         chk("s2_no_valid", {127'd0, nonce_valid}, '0);
      end

      // Back-pressure, then a single-cycle ready pulse.
      do_reset();
      mode = 0;
      push(36);
      adv_to(36);
      for (int i = 0; i < 40; i++) begin
         adv();
         chk("s3_hold_nonce", nonce_out, gen(0, 36));
         chk("s3_hold_issued", {112'd0, issued_count}, '0);
      end
      chk("s3_hold_valid", {127'd0, nonce_valid}, 128'd1);
      nonce_ready = 1'b1;
      adv();
      nonce_ready = 1'b0;
      chk("s3_issued_pulse", {112'd0, issued_count}, 128'd1);
      chk("s3_valid_drop", {127'd0, nonce_valid}, '0);
      push(80);
      adv_to(80);
      chk("s3_next_nonce", nonce_out, gen(0, 80));

      // Asynchronous reset while holding a nonce.
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("s6_async_valid", {127'd0, nonce_valid}, '0);
      chk("s6_async_nonce", nonce_out, '0);
      chk("s6_async_issued", {112'd0, issued_count}, '0);
      scenario_fresh();

      // All samples with bit0=1: APT fails on the 14th sample.
      do_reset();
      mode = 2;
      push(36);
      adv_to(56);
      chk("s4_alarm_at56", {127'd0, alarm}, '0);
      adv_to(57);
      chk("s4_alarm_at57", {127'd0, alarm}, 128'd1);
      chk("s4_valid_at57", {127'd0, nonce_valid}, '0);
      chk("s4_nonce_at57", nonce_out, '0);

      // Clear the alarm and re-warm.
      mode = 0;
      adv_to(60);
      clear_alarm = 1'b1;
      adv_to(61);
      clear_alarm = 1'b0;
      chk("s5_alarm_cleared", {127'd0, alarm}, '0);
      push(96);
      adv_to(95);
      chk("s5_valid_before", {127'd0, nonce_valid}, '0);
      adv_to(96);
      chk("s5_fresh_nonce", nonce_out, gen(0, 96));
      adv_to(100);
      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got=%0d pending expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
